mem_access_ctrl: RTL and testbench

Memory-stage access sequencer for the pipelined OTTER core. It sits between the E-to-M pipeline register outputs and a valid/ready data-memory bus, and turns each load or store in M into a single bus transaction. It stalls the pipeline while the transaction is outstanding, and generates byte enables, write-lane replication and load extraction with sign or zero extension. It also flags misaligned and timed-out accesses.

---
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the M-stage access sequencer and the memory.
// Latency: none, wires only.
// Backpressure: the master holds its request until BusReady answers it.
//
// master: BusValid/BusWE/BusAddr/BusBE/BusWData out; BusReady/BusRData in
// slave : the mirror image, for the memory model or real memory port
interface mem_access_ctrl_if;
    logic        BusValid;
    logic        BusReady;
    logic        BusWE;
    logic [31:0] BusAddr;
    logic [3:0]  BusBE;
    logic [31:0] BusWData;
    logic [31:0] BusRData;

    modport master (
        output BusValid, BusWE, BusAddr, BusBE, BusWData,
        input  BusReady, BusRData
    );

    modport slave (
        input  BusValid, BusWE, BusAddr, BusBE, BusWData,
        output BusReady, BusRData
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// M-stage access sequencer: turns each load/store into one bus transaction.
// Latency: IDLE + 1..TIMEOUT REQ cycles + DONE; misaligned goes IDLE->DONE.
// Backpressure: StallM holds F/D/E/M while the access is short of DONE.
//
// Ports:
//   CLK, RST       clock, synchronous active-high reset
//   ResultSrcM     2'b01 marks a load
//   MemWriteM      store (wins over a load marking)
//   ALUResultM     byte address
//   WriteDataM     right-aligned store data
//   MemSizeM       00 byte, 01 half, 10/11 word
//   MemSignM       1 sign-extends loads
//   bus            valid/ready data-memory bus (master side)
//   StallM         pipeline hold, combinational
//   ReadDataM      extended load result, meaningful in DONE
//   MemErr         one-cycle pulse in DONE on misalignment or timeout
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [1:0]          ResultSrcM,
    input  logic                MemWriteM,
    input  logic [31:0]         ALUResultM,
    input  logic [31:0]         WriteDataM,
    input  logic [1:0]          MemSizeM,
    input  logic                MemSignM,
    mem_access_ctrl_if.master   bus,
    output logic                StallM,
    output logic [31:0]         ReadDataM,
    output logic                MemErr
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          sign_q, sign_d;
    logic [1:0]    off_q, off_d;
    logic [31:0]   rdata_q, rdata_d;

    logic        access;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic        timeout_hit;

    // ------------------------------------------------------------------
    // Request decode from the E-to-M register outputs
    // ------------------------------------------------------------------
    always_comb begin
        access = MemWriteM | (ResultSrcM == 2'b01);

        misaligned = 1'b0;
        unique case (MemSizeM)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = ALUResultM[0];
            default: misaligned = (ALUResultM[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WriteDataM;
        unique case (MemSizeM)
            2'b00: begin
                be_calc    = 4'b0001 << ALUResultM[1:0];
                wdata_calc = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {ALUResultM[1], 1'b0};
                wdata_calc = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = WriteDataM;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load extraction, using the size/sign/offset latched at issue so the
    // result does not depend on the (stalled, but unchecked) M inputs.
    // ------------------------------------------------------------------
    always_comb begin
        rd_shift = bus.BusRData >> {off_q, 3'b000};
        rd_ext   = rd_shift;
        unique case (size_q)
            2'b00:   rd_ext = {{24{sign_q & rd_shift[7]}},  rd_shift[7:0]};
            2'b01:   rd_ext = {{16{sign_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    assign timeout_hit = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.BusReady || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.BusValid = (state_q == S_REQ);
        bus.BusWE    = we_q;
        bus.BusAddr  = addr_q;
        bus.BusBE    = be_q;
        bus.BusWData = wdata_q;
        // The held instruction stays visible in M until DONE releases it.
        StallM       = access & (state_q != S_DONE);
        MemErr       = (state_q == S_DONE) & err_q;
        ReadDataM    = rdata_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d   = cnt_q;
        err_d   = err_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        rdata_d = rdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (access && !misaligned) begin
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    we_d    = MemWriteM;
                    be_d    = be_calc;
                    wdata_d = wdata_calc;
                    size_d  = MemSizeM;
                    sign_d  = MemSignM;
                    off_d   = ALUResultM[1:0];
                    cnt_d   = '0;
                end else if (access) begin
                    err_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus.BusReady) begin
                    rdata_d = we_q ? 32'd0 : rd_ext;
                end else if (timeout_hit) begin
                    // Abandoned access: a store is simply dropped.
                    err_d   = 1'b1;
                    rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                err_d = 1'b0;
            end
            default: begin
                err_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            sign_q  <= 1'b0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  ResultSrcM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [1:0]  MemSizeM;
    logic        MemSignM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MemErr;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ResultSrcM (ResultSrcM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .MemSizeM   (MemSizeM),
        .MemSignM   (MemSignM),
        .bus        (bus_if),
        .StallM     (StallM),
        .ReadDataM  (ReadDataM),
        .MemErr     (MemErr)
    );

    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vector with hand-computed literal expectations (p*).
    typedef struct {
        bit          we;
        bit          ld;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          sgn;
        logic [31:0] wd;
        logic [31:0] rdata;
        int          wait_n;   // not-ready REQ cycles before BusReady; -1 = never
        int          pstall;
        logic [3:0]  pbe;
        logic [31:0] paddr;
        logic [31:0] pwd;
        bit          prd_v;
        logic [31:0] prd;
        bit          perr;
    } vec_t;

    vec_t vecs [16];
    vec_t cur;

    // ---------------- behavioural model ----------------
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit m_mis(input logic [31:0] addr, input logic [1:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] be;
        int off;
        off = int'(addr[1:0]);
        for (int b = 0; b < 4; b++) be[b] = (b >= off) && (b < off + nbytes(size));
        return be;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] wd, input logic [1:0] size);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = wd[8*(b % nbytes(size)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [31:0] rdata, input logic [31:0] addr,
                                         input logic [1:0] size, input bit sgn);
        logic [31:0] sh;
        logic [31:0] r;
        int w;
        sh = rdata >> (8 * int'(addr[1:0]));
        w  = 8 * nbytes(size);
        r  = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < w) r[i] = sh[i];
            else       r[i] = sgn & sh[w-1];
        end
        return r;
    endfunction

    // Expectations for the current cycle, consumed by the compare process.
    bit          cmp_en = 1'b0;
    bit          e_stall, e_valid, e_done, e_err, e_we, e_rd_v;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0]  e_be;
    int          stall_cnt;

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("stall", StallM, e_stall);
            if (StallM) stall_cnt++;
            chk("bus_valid", bus_if.BusValid, e_valid);
            if (e_valid) begin
                chk("bus_addr", bus_if.BusAddr, e_addr);
                chk("bus_we", bus_if.BusWE, e_we);
                chk("bus_be", bus_if.BusBE, e_be);
                chk("bus_wdata", bus_if.BusWData, e_wd);
                chk("pin_be", bus_if.BusBE, cur.pbe);
                chk("pin_addr", bus_if.BusAddr, cur.paddr);
                chk("pin_wdata", bus_if.BusWData, cur.pwd);
            end
            if (e_done) begin
                chk("mem_err", MemErr, e_err);
                chk("pin_err", MemErr, cur.perr);
                if (e_rd_v)     chk("read_data", ReadDataM, e_rd);
                if (cur.prd_v)  chk("pin_read_data", ReadDataM, cur.prd);
            end else begin
                chk("mem_err_quiet", MemErr, 1'b0);
            end
        end
    end

    // Runs one instruction through M; entered and left just after a posedge.
    task automatic txn(input vec_t v);
        bit access, mis, timed;
        int nreq, last;
        cur       = v;
        stall_cnt = 0;
        access    = v.we | v.ld;
        mis       = access && m_mis(v.addr, v.size);
        timed     = 1'b0;
        nreq      = 0;
        MemWriteM  = v.we;
        ResultSrcM = v.ld ? 2'b01 : 2'b10;
        ALUResultM = v.addr;
        WriteDataM = v.wd;
        MemSizeM   = v.size;
        MemSignM   = v.sgn;
        bus_if.BusRData = v.rdata;
        if (!access) begin
            last = 0;
        end else if (mis) begin
            last = 1;
        end else begin
            timed = (v.wait_n < 0) || (v.wait_n >= TO);
            nreq  = timed ? TO : v.wait_n + 1;
            last  = nreq + 1;
        end
        e_addr = {v.addr[31:2], 2'b00};
        e_we   = v.we;
        e_be   = m_be(v.addr, v.size);
        e_wd   = m_wd(v.wd, v.size);
        e_err  = mis || timed;
        e_rd   = (timed || v.we) ? 32'd0 : m_ld(v.rdata, v.addr, v.size, v.sgn);
        e_rd_v = access && !mis;
        for (int c = 0; c <= last; c++) begin
            e_stall = access && (c < last);
            e_valid = access && !mis && (c >= 1) && (c <= nreq);
            e_done  = access && (c == last);
            // Ready outside REQ must be ignored, so also raise it in IDLE/DONE.
            bus_if.BusReady = (c == 0) || (c == last) || (!timed && (c == 1 + v.wait_n));
            @(posedge CLK);
            #1;
        end
        chk("stall_len", stall_cnt, v.pstall);
    endtask

    initial begin
        //           we ld addr       sz    sg wd            rdata         wait st be    paddr      pwd           rv prd           er
        vecs[0]  = '{0, 1, 32'h100, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0,  2, 4'hF, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0};
        vecs[1]  = '{0, 1, 32'h103, 2'b00, 1, 32'h0,        32'h80112233, 0,  2, 4'h8, 32'h100, 32'h0,        1, 32'hFFFFFF80, 0};
        vecs[2]  = '{0, 1, 32'h103, 2'b00, 0, 32'h0,        32'h80112233, 0,  2, 4'h8, 32'h100, 32'h0,        1, 32'h00000080, 0};
        vecs[3]  = '{1, 0, 32'h202, 2'b01, 0, 32'h0000ABCD, 32'h0,        0,  2, 4'hC, 32'h200, 32'hABCDABCD, 1, 32'h0,        0};
        vecs[4]  = '{0, 1, 32'h101, 2'b10, 0, 32'h0,        32'h0,        0,  1, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1};
        vecs[5]  = '{0, 1, 32'h100, 2'b10, 0, 32'h0,        32'hDEADBEEF, -1, 5, 4'hF, 32'h100, 32'h0,        1, 32'h0,        1};
        vecs[6]  = '{0, 1, 32'h104, 2'b10, 0, 32'h0,        32'h12345678, 3,  5, 4'hF, 32'h104, 32'h0,        1, 32'h12345678, 0};
        vecs[7]  = '{0, 0, 32'h100, 2'b10, 0, 32'h0,        32'h0,        0,  0, 4'h0, 32'h0,   32'h0,        0, 32'h0,        0};
        vecs[8]  = '{0, 1, 32'h102, 2'b01, 1, 32'h0,        32'h80112233, 0,  2, 4'hC, 32'h100, 32'h0,        1, 32'hFFFF8011, 0};
        vecs[9]  = '{1, 0, 32'h301, 2'b00, 0, 32'h1234565A, 32'h0,        0,  2, 4'h2, 32'h300, 32'h5A5A5A5A, 1, 32'h0,        0};
        vecs[10] = '{1, 0, 32'h203, 2'b01, 0, 32'h1111,     32'h0,        0,  1, 4'h0, 32'h0,   32'h0,        0, 32'h0,        1};
        vecs[11] = '{0, 1, 32'h108, 2'b11, 1, 32'h0,        32'hCAFEF00D, 0,  2, 4'hF, 32'h108, 32'h0,        1, 32'hCAFEF00D, 0};
        vecs[12] = '{1, 1, 32'h10C, 2'b10, 0, 32'h01020304, 32'h0,        1,  3, 4'hF, 32'h10C, 32'h01020304, 1, 32'h0,        0};
        vecs[13] = '{1, 0, 32'h110, 2'b10, 0, 32'h55AA55AA, 32'h0,        -1, 5, 4'hF, 32'h110, 32'h55AA55AA, 1, 32'h0,        1};
        vecs[14] = '{0, 1, 32'h100, 2'b01, 0, 32'h0,        32'h80112233, 2,  4, 4'h3, 32'h100, 32'h0,        1, 32'h00002233, 0};
        vecs[15] = '{0, 1, 32'h100, 2'b10, 0, 32'h0,        32'hDEADBEEF, 0,  2, 4'hF, 32'h100, 32'h0,        1, 32'hDEADBEEF, 0};

        RST = 1'b1;
        ResultSrcM = 2'b00; MemWriteM = 1'b0; ALUResultM = 32'd0; WriteDataM = 32'd0;
        MemSizeM = 2'b00; MemSignM = 1'b0;
        bus_if.BusReady = 1'b0; bus_if.BusRData = 32'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", bus_if.BusValid, 1'b0);
        chk("rst_we", bus_if.BusWE, 1'b0);
        chk("rst_addr", bus_if.BusAddr, 32'd0);
        chk("rst_be", bus_if.BusBE, 4'd0);
        chk("rst_wdata", bus_if.BusWData, 32'd0);
        chk("rst_rdata", ReadDataM, 32'd0);
        chk("rst_err", MemErr, 1'b0);
        chk("rst_stall_idle", StallM, 1'b0);
        ResultSrcM = 2'b01;
        @(negedge CLK);
        chk("rst_stall_load", StallM, 1'b1);
        chk("rst_valid_load", bus_if.BusValid, 1'b0);
        ResultSrcM = 2'b00;
        @(posedge CLK);
        #1;
        RST = 1'b0;

        cmp_en = 1'b1;
        for (int i = 0; i < 15; i++) txn(vecs[i]);

        // Reset in the second REQ cycle of a word load
        cmp_en = 1'b0;
        MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h140; MemSizeM = 2'b10;
        bus_if.BusReady = 1'b0;
        @(negedge CLK);
        chk("mr_idle_stall", StallM, 1'b1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("mr_req1_valid", bus_if.BusValid, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("mr_req2_valid", bus_if.BusValid, 1'b1);
        chk("mr_req2_addr", bus_if.BusAddr, 32'h140);
        @(posedge CLK); #1;
        RST = 1'b0;
        ResultSrcM = 2'b00;
        @(negedge CLK);
        chk("mr_valid", bus_if.BusValid, 1'b0);
        chk("mr_err", MemErr, 1'b0);
        chk("mr_addr", bus_if.BusAddr, 32'd0);
        chk("mr_be", bus_if.BusBE, 4'd0);
        chk("mr_we", bus_if.BusWE, 1'b0);
        chk("mr_wdata", bus_if.BusWData, 32'd0);
        chk("mr_rdata", ReadDataM, 32'd0);
        chk("mr_stall", StallM, 1'b0);
        @(posedge CLK); #1;
        cmp_en = 1'b1;
        txn(vecs[15]);
        cmp_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
